xif_issue_arbiter: RTL

// - Shares the core's X-interface issue channel among NUM_COPROC coprocessors.
// - Broadcasts each issue request to every coprocessor and collects each coprocessor's ready/accept.
// - Returns one combined issue response to the core.
// - Records which coprocessor owns each instruction id, so that commit and result traffic can be routed.
// - Sits between the cv32e40x core issue port and the coprocessor issue monitors/units.

---
 rtl/xif_arb_pkg.sv | 17 +
 rtl/xif_owner_table.sv | 45 ++++
 rtl/xif_issue_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/xif_arb_pkg.sv
// Shared types and constants for the X-interface issue arbiter.
package xif_arb_pkg;

  localparam int MAX_COPROC = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BCAST = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] owner;
  } owner_entry_t;

endpackage

// File: rtl/xif_owner_table.sv
// Instruction-id to coprocessor ownership table.
// One write port and one clear port; a write and a clear to the same id in the
// same cycle keep the written entry. The read port is asynchronous and shows
// the state before this cycle's update. Entries are flops because every valid
// bit must clear on reset.
module xif_owner_table
  import xif_arb_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [ID_W-1:0] wr_id_i,
  input  logic [2:0]      wr_owner_i,
  input  logic            clr_en_i,
  input  logic [ID_W-1:0] clr_id_i,
  input  logic [ID_W-1:0] rd_id_i,
  output owner_entry_t    rd_entry_o
);

  localparam int DEPTH = 2 ** ID_W;

  owner_entry_t table_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Per-entry update: write has priority over clear for the same id.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          table_reg[gi] <= '0;
        end else if (wr_en_i && (wr_id_i == ID_W'(gi))) begin
          table_reg[gi].valid <= 1'b1;
          table_reg[gi].owner <= wr_owner_i;
        end else if (clr_en_i && (clr_id_i == ID_W'(gi))) begin
          table_reg[gi].valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign rd_entry_o = table_reg[rd_id_i];

endmodule

// File: rtl/xif_issue_arbiter.sv
// Shares one X-interface issue channel among NUM_COPROC coprocessors.
// Each request is broadcast to every coprocessor; per-coprocessor handshakes
// are collected into a done mask, and once all have answered (or the wait
// times out) a single combined response is returned to the core. The
// accepting coprocessor is recorded per instruction id for later routing.
module xif_issue_arbiter
  import xif_arb_pkg::*;
#(
  parameter int  NUM_COPROC = 2,
  parameter int  ID_W       = 4,
  parameter int  TIMEOUT    = 64,
  localparam int OWNER_W    = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [ID_W-1:0]       issue_id_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  output logic [NUM_COPROC-1:0] cp_valid_o,
  input  logic [NUM_COPROC-1:0] cp_ready_i,
  input  logic [NUM_COPROC-1:0] cp_accept_i,
  input  logic [NUM_COPROC-1:0] cp_writeback_i,
  output logic [31:0]           cp_instr_o,
  output logic [ID_W-1:0]       cp_id_o,
  input  logic                  result_valid_i,
  input  logic [ID_W-1:0]       result_id_i,
  input  logic [ID_W-1:0]       query_id_i,
  output logic                  owner_valid_o,
  output logic [OWNER_W-1:0]    owner_o,
  output logic                  err_multi_o,
  output logic                  err_timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_reg;
  logic [NUM_COPROC-1:0] done_reg;
  logic [NUM_COPROC-1:0] acc_reg;
  logic [NUM_COPROC-1:0] wb_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [31:0]           instr_reg;
  logic [ID_W-1:0]       id_reg;
  logic                  ready_reg;
  logic                  accept_reg;
  logic                  wb_out_reg;
  logic [OWNER_W-1:0]    winner_reg;
  logic                  multi_reg;
  logic                  timeout_reg;

  logic [NUM_COPROC-1:0] hs;
  logic [NUM_COPROC-1:0] done_next;
  logic [NUM_COPROC-1:0] acc_next;
  logic [NUM_COPROC-1:0] wb_next;
  logic [OWNER_W-1:0]    win_idx;
  logic                  wb_sel;
  logic                  any_acc;
  logic                  multi_acc;
  logic                  all_done;
  owner_entry_t          lookup;

  // Broadcast valid: each coprocessor sees valid until its own handshake.
  assign cp_valid_o = (state_reg == BCAST) ? ~done_reg : '0;
  assign hs         = cp_valid_o & cp_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COPROC; gi++) begin : g_capture
      // A coprocessor's accept/writeback is taken only in its handshake cycle.
      assign done_next[gi] = done_reg[gi] | hs[gi];
      assign acc_next[gi]  = hs[gi] ? cp_accept_i[gi]    : acc_reg[gi];
      assign wb_next[gi]   = hs[gi] ? cp_writeback_i[gi] : wb_reg[gi];
    end
  endgenerate

  assign all_done  = &done_next;
  assign any_acc   = |acc_next;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_acc = (acc_next & (acc_next - NUM_COPROC'(1))) != '0;

  // Winner select: lowest-index accepting coprocessor wins.
  always_comb begin
    win_idx = '0;
    wb_sel  = 1'b0;
    for (int k = NUM_COPROC - 1; k >= 0; k--) begin
      if (acc_next[k]) begin
        win_idx = OWNER_W'(k);
        wb_sel  = wb_next[k];
      end
    end
  end

  // Issue FSM: IDLE latches the request, BCAST collects handshakes, RESP answers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      done_reg    <= '0;
      acc_reg     <= '0;
      wb_reg      <= '0;
      cnt_reg     <= '0;
      instr_reg   <= '0;
      id_reg      <= '0;
      ready_reg   <= 1'b0;
      accept_reg  <= 1'b0;
      wb_out_reg  <= 1'b0;
      winner_reg  <= '0;
      multi_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      ready_reg   <= 1'b0;
      multi_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue_valid_i) begin
            instr_reg <= issue_instr_i;
            id_reg    <= issue_id_i;
            done_reg  <= '0;
            acc_reg   <= '0;
            wb_reg    <= '0;
            cnt_reg   <= '0;
            state_reg <= BCAST;
          end
        end
        BCAST: begin
          done_reg <= done_next;
          acc_reg  <= acc_next;
          wb_reg   <= wb_next;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          // Unanswered coprocessors never captured an accept, so a timeout
          // naturally treats them as rejecting.
          if (all_done || (cnt_reg == CNT_LAST)) begin
            state_reg   <= RESP;
            ready_reg   <= 1'b1;
            accept_reg  <= any_acc;
            wb_out_reg  <= any_acc & wb_sel;
            winner_reg  <= win_idx;
            multi_reg   <= multi_acc;
            timeout_reg <= ~all_done;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign issue_ready_o     = ready_reg;
  assign issue_accept_o    = accept_reg;
  assign issue_writeback_o = wb_out_reg;
  assign err_multi_o       = multi_reg;
  assign err_timeout_o     = timeout_reg;
  assign cp_instr_o        = instr_reg;
  assign cp_id_o           = id_reg;

  xif_owner_table #(
    .ID_W (ID_W)
  ) u_owner_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (ready_reg & accept_reg),
    .wr_id_i    (id_reg),
    .wr_owner_i (3'(winner_reg)),
    .clr_en_i   (result_valid_i),
    .clr_id_i   (result_id_i),
    .rd_id_i    (query_id_i),
    .rd_entry_o (lookup)
  );

  assign owner_valid_o = lookup.valid;
  assign owner_o       = lookup.owner[OWNER_W-1:0];

endmodule
